vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_if.sv | 22 ++
 rtl/vga_timing_gen.sv | 141 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and the video path.
// The generator drives coordinates, syncs and strobes; the consumer drives en.
interface vga_timing_gen_if;
   logic        en;
   logic [10:0] hc;
   logic [10:0] vc;
   logic        hsync;
   logic        vsync;
   logic        blank;
   logic        line_start;
   logic        frame_start;

   modport master (
      input  en,
      output hc, vc, hsync, vsync, blank, line_start, frame_start
   );

   modport slave (
      output en,
      input  hc, vc, hsync, vsync, blank, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enabled h/v counters with region FSMs.
// All outputs are decoded from next-state values so they align with hc/vc.
module vga_timing_gen #(
   parameter int H_ACTIVE = 1024,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 160,
   parameter int V_ACTIVE = 768,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 29,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0
) (
   input logic              clk,
   input logic              rst,
   vga_timing_gen_if.master vif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE - 1);
   localparam logic [10:0] H_FP_END   = 11'(H_ACTIVE + H_FP - 1);
   localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);

   localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE - 1);
   localparam logic [10:0] V_FP_END   = 11'(V_ACTIVE + V_FP - 1);
   localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);

   localparam logic HS_ON = 1'(HS_POL);
   localparam logic VS_ON = 1'(VS_POL);

   typedef enum logic [1:0] {
      H_ACT,
      H_FRONT,
      H_PULSE,
      H_BACK
   } h_state_e;

   typedef enum logic [1:0] {
      V_ACT,
      V_FRONT,
      V_PULSE,
      V_BACK
   } v_state_e;

   h_state_e    h_state_q, h_state_d;
   v_state_e    v_state_q, v_state_d;
   logic [10:0] hc_q, hc_d;
   logic [10:0] vc_q, vc_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        blank_q, blank_d;
   logic        line_start_q, line_start_d;
   logic        frame_start_q, frame_start_d;
   logic        h_wrap;
   logic        v_wrap;

   assign h_wrap = (hc_q == H_LAST);
   assign v_wrap = (vc_q == V_LAST);

   // Next counters, region states and strobes; everything holds when en is low
   always_comb begin
      hc_d          = hc_q;
      vc_d          = vc_q;
      h_state_d     = h_state_q;
      v_state_d     = v_state_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;

      if (vif.en) begin
         hc_d = h_wrap ? 11'd0 : hc_q + 11'd1;

         unique case (h_state_q)
            H_ACT:   if (hc_q == H_ACT_END)  h_state_d = H_FRONT;
            H_FRONT: if (hc_q == H_FP_END)   h_state_d = H_PULSE;
            H_PULSE: if (hc_q == H_SYNC_END) h_state_d = H_BACK;
            H_BACK:  if (h_wrap)             h_state_d = H_ACT;
            default: h_state_d = H_ACT;
         endcase

         if (h_wrap) begin
            vc_d         = v_wrap ? 11'd0 : vc_q + 11'd1;
            line_start_d = 1'b1;
            frame_start_d = v_wrap;

            unique case (v_state_q)
               V_ACT:   if (vc_q == V_ACT_END)  v_state_d = V_FRONT;
               V_FRONT: if (vc_q == V_FP_END)   v_state_d = V_PULSE;
               V_PULSE: if (vc_q == V_SYNC_END) v_state_d = V_BACK;
               V_BACK:  if (v_wrap)             v_state_d = V_ACT;
               default: v_state_d = V_ACT;
            endcase
         end
      end
   end

   // Level outputs decoded from the next states so they match next hc/vc
   always_comb begin
      hsync_d = (h_state_d == H_PULSE) ? HS_ON : ~HS_ON;
      vsync_d = (v_state_d == V_PULSE) ? VS_ON : ~VS_ON;
      blank_d = ~((h_state_d == H_ACT) && (v_state_d == V_ACT));
   end

   // State and output registers with synchronous reset to the raster origin
   always_ff @(posedge clk) begin
      if (rst) begin
         hc_q          <= '0;
         vc_q          <= '0;
         h_state_q     <= H_ACT;
         v_state_q     <= V_ACT;
         hsync_q       <= ~HS_ON;
         vsync_q       <= ~VS_ON;
         blank_q       <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         h_state_q     <= h_state_d;
         v_state_q     <= v_state_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         blank_q       <= blank_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vif.hc          = hc_q;
   assign vif.vc          = vc_q;
   assign vif.hsync       = hsync_q;
   assign vif.vsync       = vsync_q;
   assign vif.blank       = blank_q;
   assign vif.line_start  = line_start_q;
   assign vif.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small rasters checked against a frame-position
// model (hc/vc derived by div/mod of the pixel index within the frame).
module tb_vga_timing_gen;

   // Config A: the small set, hsync active-high
   localparam int A_HA = 8, A_HF = 2, A_HS = 2, A_HB = 2;
   localparam int A_VA = 4, A_VF = 1, A_VS = 1, A_VB = 1;
   localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
   localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
   // Config B: slightly larger, hsync active-low, vsync active-high
   localparam int B_HA = 16, B_HF = 3, B_HS = 4, B_HB = 5;
   localparam int B_VA = 6, B_VF = 2, B_VS = 2, B_VB = 3;
   localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
   localparam int B_VT = B_VA + B_VF + B_VS + B_VB;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vga_timing_gen_if a_if ();
   vga_timing_gen_if b_if ();

   vga_timing_gen #(
      .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
      .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
      .HS_POL(1), .VS_POL(0)
   ) u_a (
      .clk(clk),
      .rst(rst),
      .vif(a_if.master)
   );

   vga_timing_gen #(
      .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
      .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
      .HS_POL(0), .VS_POL(1)
   ) u_b (
      .clk(clk),
      .rst(rst),
      .vif(b_if.master)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: position within the frame plus strobe flags
   int pa = 0, pb = 0;
   logic lsa = 1'b0, fsa = 1'b0, lsb = 1'b0, fsb = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         pa <= 0; lsa <= 1'b0; fsa <= 1'b0;
      end else if (a_if.en) begin
         pa  <= (pa + 1) % (A_HT * A_VT);
         lsa <= ((pa + 1) % A_HT) == 0;
         fsa <= ((pa + 1) % (A_HT * A_VT)) == 0;
      end else begin
         lsa <= 1'b0; fsa <= 1'b0;
      end
      if (rst) begin
         pb <= 0; lsb <= 1'b0; fsb <= 1'b0;
      end else if (b_if.en) begin
         pb  <= (pb + 1) % (B_HT * B_VT);
         lsb <= ((pb + 1) % B_HT) == 0;
         fsb <= ((pb + 1) % (B_HT * B_VT)) == 0;
      end else begin
         lsb <= 1'b0; fsb <= 1'b0;
      end
   end

   task automatic cmp_unit(
      input string nm, input int ht, input int ha, input int hs0,
      input int hs1, input int va, input int vs0, input int vs1,
      input bit hpol, input bit vpol, input int p, input bit ls,
      input bit fs, input logic [10:0] hc, input logic [10:0] vc,
      input logic hsy, input logic vsy, input logic bl,
      input logic ols, input logic ofs);
      int eh, ev;
      bit ehs, evs, ebl;
      eh  = p % ht;
      ev  = p / ht;
      ehs = (eh >= hs0 && eh < hs1) ? hpol : !hpol;
      evs = (ev >= vs0 && ev < vs1) ? vpol : !vpol;
      ebl = !(eh < ha && ev < va);
      check({nm, ".hc"}, 32'(hc), 32'(eh));
      check({nm, ".vc"}, 32'(vc), 32'(ev));
      check({nm, ".hsync"}, 32'(hsy), 32'(ehs));
      check({nm, ".vsync"}, 32'(vsy), 32'(evs));
      check({nm, ".blank"}, 32'(bl), 32'(ebl));
      check({nm, ".line_start"}, 32'(ols), 32'(ls));
      check({nm, ".frame_start"}, 32'(ofs), 32'(fs));
   endtask

   // Enabled-edge counts between frame strobes
   int  cnt_a = 0, cnt_b = 0;
   bit  seen_a = 0, seen_b = 0;

   task automatic cycle(input bit r, input bit ea, input bit eb);
      rst     = r;
      a_if.en = ea;
      b_if.en = eb;
      @(negedge clk);
      cmp_unit("A", A_HT, A_HA, A_HA + A_HF, A_HA + A_HF + A_HS,
               A_VA, A_VA + A_VF, A_VA + A_VF + A_VS, 1'b1, 1'b0,
               pa, lsa, fsa, a_if.hc, a_if.vc, a_if.hsync, a_if.vsync,
               a_if.blank, a_if.line_start, a_if.frame_start);
      cmp_unit("B", B_HT, B_HA, B_HA + B_HF, B_HA + B_HF + B_HS,
               B_VA, B_VA + B_VF, B_VA + B_VF + B_VS, 1'b0, 1'b1,
               pb, lsb, fsb, b_if.hc, b_if.vc, b_if.hsync, b_if.vsync,
               b_if.blank, b_if.line_start, b_if.frame_start);
      if (r) begin
         seen_a = 0; seen_b = 0; cnt_a = 0; cnt_b = 0;
      end else begin
         if (ea) cnt_a++;
         if (eb) cnt_b++;
         if (a_if.frame_start === 1'b1) begin
            if (seen_a) check("A.frame_period", 32'(cnt_a), 32'd98);
            seen_a = 1; cnt_a = 0;
         end
         if (b_if.frame_start === 1'b1) begin
            if (seen_b) check("B.frame_period", 32'(cnt_b), 32'd364);
            seen_b = 1; cnt_b = 0;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      a_if.en = 1'b0;
      b_if.en = 1'b0;
      repeat (3) cycle(1'b1, 1'b1, 1'b1);

      // Free-running, one pixel per clock
      for (int i = 0; i < 800; i++) cycle(1'b0, 1'b1, 1'b1);

      // Enable at 1-in-3
      for (int i = 0; i < 1500; i++)
         cycle(1'b0, (i % 3) == 0, (i % 3) == 0);

      // Directed mid-frame reset on B while enabled
      for (int i = 0; i < 2000 && pb != 5 * B_HT + 7; i++)
         cycle(1'b0, 1'b1, 1'b1);
      check("B.pre_reset_vc", 32'(b_if.vc), 32'd5);
      cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);

      // Random enables with occasional resets
      for (int i = 0; i < 4000; i++)
         cycle(($urandom % 600) == 0, ($urandom % 4) != 0,
               ($urandom % 3) != 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
